// File: rtl/elevator_pkg.sv
// Shared constants, FSM state encoding and floor-search helpers for the
// floor request queue.
package elevator_pkg;

  localparam int unsigned N_FLOORS = 4;
  localparam int unsigned FLOOR_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_MOVING = 2'd3
  } state_t;

  typedef struct packed {
    logic               found;
    logic [FLOOR_W-1:0] floor;
  } search_t;

  // Lowest pending floor strictly above cur (scan top-down, last hit wins).
  function automatic search_t search_above(input logic [N_FLOORS-1:0] pend,
                                           input logic [FLOOR_W-1:0]  cur);
    search_t            r;
    logic [FLOOR_W-1:0] fl;
    r = '0;
    for (int unsigned k = 0; k < N_FLOORS; k++) begin
      fl = FLOOR_W'(N_FLOORS - 1 - k);
      if (pend[fl] && (fl > cur)) begin
        r.found = 1'b1;
        r.floor = fl;
      end
    end
    return r;
  endfunction

  // Highest pending floor strictly below cur (scan bottom-up, last hit wins).
  function automatic search_t search_below(input logic [N_FLOORS-1:0] pend,
                                           input logic [FLOOR_W-1:0]  cur);
    search_t            r;
    logic [FLOOR_W-1:0] fl;
    r = '0;
    for (int unsigned k = 0; k < N_FLOORS; k++) begin
      fl = FLOOR_W'(k);
      if (pend[fl] && (fl < cur)) begin
        r.found = 1'b1;
        r.floor = fl;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One call button: 2-flop synchronizer, saturating tick counter and a
// single-cycle press pulse on the cycle the counter first reaches TICKS.
module button_debounce #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en_i,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [3:0] TICKS_L = 4'(TICKS);

  logic       sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;

  // Synchronizer chain for the raw asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count ticks while the level is high; any low cycle restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (tick_en_i && (cnt_q != TICKS_L)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires only on the increment that lands on TICKS; saturation blocks repeats.
  always_comb begin
    press_o = sync2_q && tick_en_i && (cnt_q == (TICKS_L - 4'd1));
  end

endmodule

// File: rtl/floor_request_queue.sv
// Collects debounced floor calls into a pending mask and hands targets to
// the elevator stage one at a time with a valid/ready handshake, sweeping
// in the current direction before reversing.
module floor_request_queue
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_en,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]  cur_floor,
  input  logic                arrived,
  input  logic                req_ready,
  output logic                req_valid,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up
);

  logic [N_FLOORS-1:0] press;
  logic [N_FLOORS-1:0] set_mask, clr_mask;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  target_q, target_d;
  logic                dir_up_q, dir_up_d;
  search_t             up_s, dn_s;

  for (genvar g = 0; g < N_FLOORS; g++) begin : g_btn
    button_debounce #(
      .TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .tick_en_i(tick_en),
      .btn_i    (call_btn[g]),
      .press_o  (press[g])
    );
  end

  // Pending update: calls at the idle car's own floor are dropped, and an
  // arrival clear overrides a same-cycle set on that floor.
  always_comb begin
    set_mask = press;
    if (state_q == ST_IDLE) begin
      set_mask[cur_floor] = 1'b0;
    end
    clr_mask = '0;
    if (arrived) begin
      clr_mask[cur_floor] = 1'b1;
    end
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  // Pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Candidate targets in both directions from the current floor.
  always_comb begin
    up_s = search_above(pending_q, cur_floor);
    dn_s = search_below(pending_q, cur_floor);
  end

  // FSM state, target and direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dir_up_q <= dir_up_d;
    end
  end

  // Next-state, target selection and direction reversal.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (pending_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
          // Reverse only when the other side has work; a call left only at
          // the current floor is served in place without flipping direction.
          if (dir_up_q) begin
            if (up_s.found) begin
              target_d = up_s.floor;
            end else if (dn_s.found) begin
              target_d = dn_s.floor;
              dir_up_d = 1'b0;
            end else begin
              target_d = cur_floor;
            end
          end else begin
            if (dn_s.found) begin
              target_d = dn_s.floor;
            end else if (up_s.found) begin
              target_d = up_s.floor;
              dir_up_d = 1'b1;
            end else begin
              target_d = cur_floor;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (req_ready) state_d = ST_MOVING;
      end
      ST_MOVING: begin
        if (arrived && (cur_floor == target_q)) begin
          state_d = (pending_d != '0) ? ST_SELECT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    req_valid    = (state_q == ST_ISSUE);
    target_floor = target_q;
    dir_up       = dir_up_q;
    pending      = pending_q;
  end

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue: a table of single-press scenarios
// plus hand-written multi-cycle sequences.
module tb_floor_request_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic [3:0] call_btn;
  logic [1:0] cur_floor;
  logic       arrived;
  logic       req_ready;
  logic       req_valid;
  logic [1:0] target_floor;
  logic [3:0] pending;
  logic       dir_up;

  int n_tests = 0;
  int n_fail  = 0;

  floor_request_queue #(.DEBOUNCE_TICKS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .call_btn    (call_btn),
    .cur_floor   (cur_floor),
    .arrived     (arrived),
    .req_ready   (req_ready),
    .req_valid   (req_valid),
    .target_floor(target_floor),
    .pending     (pending),
    .dir_up      (dir_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cur;
    logic [3:0] btn;
    logic [3:0] exp_pend;
    logic       exp_valid;
    logic [1:0] exp_tgt;
    logic       exp_dir;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick_en = 1'b0; call_btn = '0; arrived = 1'b0; req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    tick_en = 1'b1;
    @(negedge clk);
    tick_en = 1'b0;
  endtask

  task automatic set_btn(input logic [3:0] m);
    call_btn = m;
    repeat (3) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int n);
    set_btn(m);
    for (int k = 0; k < n; k++) begin
      tick();
      @(negedge clk);
    end
    set_btn(4'b0000);
  endtask

  task automatic arrive(input logic [1:0] f);
    cur_floor = f;
    arrived = 1'b1;
    @(negedge clk);
    arrived = 1'b0;
  endtask

  task automatic handshake();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //               cur    btn      pend     vld   tgt    dir
    vecs[0] = '{2'd0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[1] = '{2'd2, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[2] = '{2'd3, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[3] = '{2'd1, 4'b1001, 4'b1001, 1'b1, 2'd3, 1'b1};
    vecs[4] = '{2'd2, 4'b0011, 4'b0011, 1'b1, 2'd1, 1'b0};
    vecs[5] = '{2'd0, 4'b1110, 4'b1110, 1'b1, 2'd1, 1'b1};
    vecs[6] = '{2'd3, 4'b0111, 4'b0111, 1'b1, 2'd2, 1'b0};
    vecs[7] = '{2'd1, 4'b0110, 4'b0100, 1'b1, 2'd2, 1'b1};

    rst = 1'b1; tick_en = 1'b0; call_btn = '0; cur_floor = '0;
    arrived = 1'b0; req_ready = 1'b0;
    #12;
    check("reset_req_valid", 32'(req_valid), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_target", 32'(target_floor), 32'd0);
    check("reset_dir_up", 32'(dir_up), 32'd1);

    // Table: single press from idle, then check the issued request.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      cur_floor = vecs[i].cur;
      press(vecs[i].btn, 6);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      check($sformatf("vec%0d_valid", i), 32'(req_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_target", i), 32'(target_floor), 32'(vecs[i].exp_tgt));
      check($sformatf("vec%0d_dir", i), 32'(dir_up), 32'(vecs[i].exp_dir));
    end

    // Press latency: pending after the 4th tick, req_valid two cycles later.
    do_reset();
    cur_floor = 2'd0;
    set_btn(4'b0100);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("lat_pend_tick%0d", k), 32'(pending), 32'd0);
      @(negedge clk);
    end
    tick();
    check("lat_pend_tick4", 32'(pending), 32'b0100);
    check("lat_valid_plus0", 32'(req_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_plus1", 32'(req_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_plus2", 32'(req_valid), 32'd1);
    check("lat_target", 32'(target_floor), 32'd2);
    check("lat_dir", 32'(dir_up), 32'd1);
    tick(); @(negedge clk); tick(); @(negedge clk);
    set_btn(4'b0000);
    check("lat_held_pending", 32'(pending), 32'b0100);

    // Bounce: 1-0-1 then steady high; event only on the 4th steady tick.
    do_reset();
    cur_floor = 2'd0;
    set_btn(4'b0010); tick(); @(negedge clk);
    set_btn(4'b0000); tick(); @(negedge clk);
    set_btn(4'b0010);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("bounce_pend_tick%0d", k), 32'(pending), 32'd0);
      @(negedge clk);
    end
    tick();
    check("bounce_pend_tick4", 32'(pending), 32'b0010);
    @(negedge clk);
    set_btn(4'b0000);

    // Sweep up to 3, then reverse down to 0.
    do_reset();
    cur_floor = 2'd1;
    press(4'b1001, 6);
    repeat (2) @(negedge clk);
    check("sweep_target3", 32'(target_floor), 32'd3);
    check("sweep_dir_up", 32'(dir_up), 32'd1);
    handshake();
    check("sweep_moving_valid", 32'(req_valid), 32'd0);
    arrive(2'd3);
    check("sweep_pend_after_arr", 32'(pending), 32'b0001);
    @(negedge clk);
    check("sweep_valid2", 32'(req_valid), 32'd1);
    check("sweep_target0", 32'(target_floor), 32'd0);
    check("sweep_dir_down", 32'(dir_up), 32'd0);

    // Stall: ready low while another call arrives; target must not move.
    do_reset();
    cur_floor = 2'd0;
    press(4'b0100, 6);
    press(4'b1000, 6);
    check("stall_valid", 32'(req_valid), 32'd1);
    check("stall_target", 32'(target_floor), 32'd2);
    check("stall_pending", 32'(pending), 32'b1100);
    handshake();
    check("stall_hs_valid", 32'(req_valid), 32'd0);
    check("stall_hs_target", 32'(target_floor), 32'd2);
    arrive(2'd2);
    @(negedge clk);
    check("stall_next_valid", 32'(req_valid), 32'd1);
    check("stall_next_target", 32'(target_floor), 32'd3);

    // Pass-through arrival at a non-target floor while moving.
    do_reset();
    cur_floor = 2'd0;
    press(4'b1000, 6);
    handshake();
    press(4'b0010, 6);
    check("pass_pending_before", 32'(pending), 32'b1010);
    arrive(2'd1);
    check("pass_pending_after", 32'(pending), 32'b1000);
    repeat (3) @(negedge clk);
    check("pass_still_moving", 32'(req_valid), 32'd0);
    check("pass_target", 32'(target_floor), 32'd3);
    arrive(2'd3);
    repeat (3) @(negedge clk);
    check("pass_done_pending", 32'(pending), 32'd0);
    check("pass_done_valid", 32'(req_valid), 32'd0);
    press(4'b1000, 6);
    check("pass_idle_ignore", 32'(pending), 32'd0);

    // Asynchronous reset in ISSUE.
    do_reset();
    cur_floor = 2'd3;
    press(4'b0001, 6);
    check("arst_pre_valid", 32'(req_valid), 32'd1);
    check("arst_pre_dir", 32'(dir_up), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(req_valid), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_dir", 32'(dir_up), 32'd1);
    check("arst_target", 32'(target_floor), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_floor = 2'd0;
    press(4'b0100, 6);
    check("arst_resume_valid", 32'(req_valid), 32'd1);
    check("arst_resume_target", 32'(target_floor), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floor_request_queue.md
FLOOR_REQUEST_QUEUE -- requirements
Module: floor_request_queue

Interface
REQ-001 Parameter: DEBOUNCE_TICKS, default 4, number of consecutive tick_en samples a button must be high to count as a press (legal 1..15).
REQ-002 clk  input  1  system clock; the single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick_en  input  1  sampling strobe, one clk cycle wide, used for debounce timing only.
REQ-005 call_btn  input  4  raw, asynchronous floor-call buttons, bit f = floor f.
REQ-006 cur_floor  input  2  current floor reported by the elevator stage.
REQ-007 arrived  input  1  one-cycle pulse: elevator stopped at cur_floor.
REQ-008 req_ready  input  1  elevator stage accepts a new target this cycle.
REQ-009 req_valid  output  1  target_floor is valid and held.
REQ-010 target_floor  output  2  next floor the elevator is sent to.
REQ-011 pending  output  4  registered outstanding calls, bit f = floor f.
REQ-012 dir_up  output  1  current service direction, 1 = up.

Function
REQ-013 Each call_btn bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 Debounce: per-button 4-bit counter SHALL increment on tick_en while the synchronized level is 1, saturate at DEBOUNCE_TICKS, clear to 0 on any cycle the level is 0.
REQ-015 A press event SHALL be a single-cycle pulse on the cycle the counter first reaches DEBOUNCE_TICKS; a held button SHALL produce exactly one event until released.
REQ-016 pending[f] SHALL set the cycle after a press event on f, unless state is IDLE and cur_floor == f (call ignored).
REQ-017 On arrived, pending[cur_floor] SHALL clear the following cycle; clear wins over a same-cycle set on that floor.
REQ-018 FSM states: IDLE, SELECT, ISSUE, MOVING.
REQ-019 IDLE -> SELECT when pending != 0.
REQ-020 SELECT (one cycle): if dir_up, target = lowest pending floor > cur_floor; else highest pending floor < cur_floor; if none in that direction, dir_up SHALL invert and the search repeats in the new direction the same cycle; if pending == 0 (all cleared) -> IDLE.
REQ-021 SELECT -> ISSUE with target_floor registered; req_valid SHALL be 1 in ISSUE only.
REQ-022 ISSUE: target_floor and req_valid SHALL hold stable until req_ready = 1; on req_valid && req_ready -> MOVING.
REQ-023 MOVING: arrived with cur_floor == target_floor -> SELECT if other pending bits remain, else IDLE.
REQ-024 MOVING: arrived at a non-target floor SHALL clear that floor's pending bit and remain in MOVING.
REQ-025 New calls during ISSUE/MOVING SHALL set pending but SHALL NOT change the in-flight target_floor.
REQ-026 Latency: press event to req_valid = 3 clk cycles from IDLE (pending set, SELECT, ISSUE).

Reset
REQ-027 rst SHALL asynchronously clear synchronizers, counters, pending = 0, req_valid = 0, target_floor = 0, dir_up = 1, state = IDLE.
REQ-028 rst mid-operation SHALL drop any in-flight request without completing the handshake; operation resumes from IDLE on the first clk after release.

Structure
REQ-029 Shared package elevator_pkg SHALL hold N_FLOORS = 4, FLOOR_W = 2 and the FSM state encoding.
REQ-030 One sub-module, button_debounce (synchronizer + counter + edge pulse), SHALL be instantiated 4 times; selection logic and FSM SHALL stay in floor_request_queue.

Verification
REQ-031 Press btn 2 for 6 ticks at cur_floor 0 -> pending = 0100 one cycle after 4th tick, req_valid with target 2 two cycles later, dir_up = 1.
REQ-032 Button bounce 1-0-1 over 3 ticks then stable for 4 ticks -> exactly one pending set, no earlier event.
REQ-033 At cur_floor 1, dir_up = 1, pending = 1001 -> target 3; after arrival at 3, target 0 with dir_up = 0.
REQ-034 req_ready held 0 for 10 cycles while btn 3 pressed -> target_floor stays 2, pending becomes 1100, handshake completes on req_ready.
REQ-035 arrived at floor 1 while MOVING to 3 with pending = 1010 -> pending = 1000, state stays MOVING.
REQ-036 rst asserted in ISSUE between clk edges -> req_valid and pending drop to 0 immediately, dir_up = 1.
